// File: rtl/key_step_ctrl.sv
// Button step controller: sync/debounce two buttons, step a wrapping value, drive HEX1_D.
// Optional held-button auto-repeat is built when KEY_STEP_AUTO_REPEAT_EN is defined.

module key_step_deb #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          dly_q, dly_d;

  // The level flips one cycle after the counter has recorded DEBOUNCE_CYCLES mismatches.
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    dly_d  = lvl_q;
    if (sync_q[1] == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
      lvl_d = ~lvl_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      dly_q  <= dly_d;
    end
  end

  assign level = lvl_q;
  assign press = lvl_q & ~dly_q;
endmodule

module key_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_VAL         = 9,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [3:0] value,
  output logic       step_pulse,
  output logic [6:0] HEX1_D
);
  typedef enum logic [1:0] {IDLE, HELD_UP, HELD_DN} state_t;

  localparam logic [3:0] MAXV = 4'(MAX_VAL);

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0] db_lvl, press;

  key_step_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [1:0] (
    .clk    (clk),
    .rst    (rst),
    .btn_raw({btn_dn, btn_up}),
    .level  (db_lvl),
    .press  (press)
  );

  state_t     state_q, state_d;
  logic [3:0] value_q, value_d;
  logic       step_q, step_d;
  logic [6:0] seg_q, seg_d;

`ifdef KEY_STEP_AUTO_REPEAT_EN
  localparam int TW = $clog2(REPEAT_DELAY + 1);
  logic [TW-1:0] timer_q, timer_d;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  function automatic logic [3:0] val_inc(input logic [3:0] v);
    return (v == MAXV) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] val_dec(input logic [3:0] v);
    return (v == 4'd0) ? MAXV : v - 4'd1;
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    step_d  = 1'b0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef KEY_STEP_AUTO_REPEAT_EN
        timer_d = '0;
`endif
        // Simultaneous presses cancel; each button must be released and pressed again.
        if (press[0] && !press[1]) begin
          state_d = HELD_UP;
          value_d = val_inc(value_q);
          step_d  = 1'b1;
        end else if (press[1] && !press[0]) begin
          state_d = HELD_DN;
          value_d = val_dec(value_q);
          step_d  = 1'b1;
        end
      end
      HELD_UP, HELD_DN: begin
        if (!db_lvl[(state_q == HELD_DN) ? 1 : 0]) begin
          state_d = IDLE;
        end else begin
`ifdef KEY_STEP_AUTO_REPEAT_EN
          // Reload to DELAY-PERIOD so later repeats land every PERIOD cycles.
          timer_d = timer_q + 1'b1;
          if (timer_q == TW'(REPEAT_DELAY - 1)) begin
            timer_d = TW'(REPEAT_DELAY - REPEAT_PERIOD);
            value_d = (state_q == HELD_UP) ? val_inc(value_q) : val_dec(value_q);
            step_d  = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    seg_d = hex_seg(value_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      value_q <= 4'd0;
      step_q  <= 1'b0;
      seg_q   <= 7'b1000000;
`ifdef KEY_STEP_AUTO_REPEAT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      step_q  <= step_d;
      seg_q   <= seg_d;
`ifdef KEY_STEP_AUTO_REPEAT_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign value      = value_q;
  assign step_pulse = step_q;
  assign HEX1_D     = seg_q;
endmodule

// File: tb/tb_key_step_ctrl.sv
// Self-checking bench for key_step_ctrl: directed and random button scripts
// scored against an interval-based model of debounced levels and press rules.

module tb_key_step_ctrl;
  localparam int D  = 4;
  localparam int MV = 9;
`ifdef KEY_STEP_AUTO_REPEAT_EN
  localparam int RD = 32;
  localparam int RP = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [3:0] value;
  logic       step_pulse;
  logic [6:0] HEX1_D;

  int vectors = 0;
  int miscompares = 0;

  // Model state: expected value, held state (0 idle, 1 up, 2 down), edge of initial step.
  int m_val = 0;
  int m_st  = 0;
  int m_t0  = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  key_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .MAX_VAL        (MV),
    .REPEAT_DELAY   (32),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .value     (value),
    .step_pulse(step_pulse),
    .HEX1_D    (HEX1_D)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_step);
    check({tag, "/step"}, 32'(step_pulse), 32'(exp_step));
    check({tag, "/value"}, 32'(value), 32'(m_val));
    check({tag, "/hex"}, 32'(HEX1_D), 32'(seg_tab[m_val]));
  endtask

  function automatic int inc(input int v);
    return (v == MV) ? 0 : v + 1;
  endfunction

  function automatic int dec(input int v);
    return (v == 0) ? MV : v - 1;
  endfunction

  // Debounced level after edge t for a raw pulse first sampled at edge s, h cycles long.
  function automatic bit lvl(input int t, input int s, input int h);
    return (h >= D + 1) && (t >= s + D + 2) && (t < s + h + D + 2);
  endfunction

  task automatic run(input string tag, input int su, input int hu, input int sd, input int hd);
    int len;
    bit ul1, ul2, dl1, dl2, pu, pd, stp;
    len = ((su + hu > sd + hd) ? su + hu : sd + hd) + D + 6;
    ul1 = 0; ul2 = 0; dl1 = 0; dl2 = 0;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      btn_up = (t >= su) && (t < su + hu);
      btn_dn = (t >= sd) && (t < sd + hd);
      @(posedge clk);
      #1;
      pu = ul1 && !ul2;
      pd = dl1 && !dl2;
      stp = 0;
      case (m_st)
        0: begin
          if (pu && !pd) begin
            m_val = inc(m_val); m_st = 1; m_t0 = t; stp = 1;
          end else if (pd && !pu) begin
            m_val = dec(m_val); m_st = 2; m_t0 = t; stp = 1;
          end
        end
        default: begin
          if (!((m_st == 1) ? ul1 : dl1)) m_st = 0;
`ifdef KEY_STEP_AUTO_REPEAT_EN
          else if (t - m_t0 >= RD && (t - m_t0 - RD) % RP == 0) begin
            m_val = (m_st == 1) ? inc(m_val) : dec(m_val);
            stp = 1;
          end
`endif
        end
      endcase
      ul2 = ul1; ul1 = lvl(t, su, hu);
      dl2 = dl1; dl1 = lvl(t, sd, hd);
      check_out(tag, stp);
    end
  endtask

  task automatic reset_pulse(input int cycles);
    @(negedge clk);
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      m_val = 0; m_st = 0;
      check_out("reset", 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int btn, h, s;
    reset_pulse(3);

    // First press: step at edge k+D+3, then only repeats (if built) while held.
    run("hold_up", 0, 40, 0, 0);
    run("glitch", 1, D - 1, 0, 0);
    run("glitch_dn", 0, 0, 2, 2);

    // Wrap in both directions.
    while (m_val != MV) run("to_max", 0, D + 3, 0, 0);
    run("wrap_up", 0, D + 3, 0, 0);
    check("wrap_up_zero", 32'(value), 32'd0);
    run("wrap_dn", 0, 0, 0, D + 3);
    check("wrap_dn_max", 32'(value), 32'(MV));

    // Arbitration.
    run("both", 1, 8, 1, 8);
    run("up_then_dn", 0, 30, 10, 8);
    run("dn_outlasts_up", 0, 14, 6, 30);
    run("up_after_both", 0, D + 3, 0, 0);

    // Random single-button scripts, some of them glitches.
    for (int i = 0; i < 20; i++) begin
      btn = $urandom_range(0, 1);
      s   = $urandom_range(0, 3);
      h   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D - 1) : $urandom_range(D + 2, 3 * D);
      if (btn == 0) run("rand_up", s, h, 0, 0);
      else          run("rand_dn", 0, 0, s, h);
    end

    // Reset while held down at value 3; the still-held button steps again after reset.
    reset_pulse(1);
    for (int i = 0; i < 4; i++) run("to_four", 0, D + 3, 0, 0);
    @(negedge clk);
    btn_dn = 1'b1;
    for (int t = 0; t <= D + 6; t++) begin
      @(posedge clk);
      #1;
      if (t == D + 3) begin m_val = 3; m_st = 2; end
      check_out("hold_dn", t == D + 3);
      if (t < D + 6) @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_val = 0; m_st = 0;
    check_out("rst_mid_hold", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 1; t <= D + 7; t++) begin
      @(posedge clk);
      #1;
      if (t == D + 4) begin m_val = 9; m_st = 2; end
      check_out("rehold_dn", t == D + 4);
    end
    run("release", 0, 0, 0, 0);
    check("final_value", 32'(value), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
